ricpu_ctrl: RTL and testbench

- Multi-cycle control unit for the R/I-type CPU datapath (PC, IR, register file, ALU, flag register, data RAM).
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath write enable and mux select.
- Counts retired instructions and flags illegal opcodes.

---
 rtl/ricpu_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ricpu_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ricpu_ctrl.sv
// Multi-cycle control unit for the R/I-type CPU datapath.
// Sequences IF/ID/EX/MEM/WB and drives all enables and selects.
module ricpu_ctrl #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zf,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             rd_sel,
  output logic             wb_sel,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             fr_write,
  output logic             mem_write,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] S_IF    = 4'd0;
  localparam logic [3:0] S_ID    = 4'd1;
  localparam logic [3:0] S_EXR   = 4'd2;
  localparam logic [3:0] S_EXI   = 4'd3;
  localparam logic [3:0] S_WB    = 4'd4;
  localparam logic [3:0] S_MADDR = 4'd5;
  localparam logic [3:0] S_MRD   = 4'd6;
  localparam logic [3:0] S_MWB   = 4'd7;
  localparam logic [3:0] S_MWR   = 4'd8;
  localparam logic [3:0] S_BR    = 4'd9;
  localparam logic [3:0] S_J     = 4'd10;
  localparam logic [3:0] S_HALT  = 4'd15;

  logic [3:0] state, state_nxt;
  logic       r_ok, i_ok;
  logic [2:0] r_alu, i_alu, ex_alu;
  logic [1:0] i_srcb, ex_srcb;
  logic       is_r, is_i, is_m, is_br, is_j, is_ill;

  logic       pw_c, iw_c, rw_c, rs_c, ws_c;
  logic       fw_c, mw_c, dn_c;
  logic [1:0] ps_c, sb_c;
  logic [2:0] ao_c;

  // Decode the held IR fields into instruction class and ALU setup
  always_comb begin
    r_ok   = 1'b1;
    r_alu  = 3'b100;
    i_ok   = 1'b1;
    i_alu  = 3'b100;
    i_srcb = 2'b10;
    case (funct)
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b100110: r_alu = 3'b010;
      6'b100111: r_alu = 3'b011;
      6'b100000: r_alu = 3'b100;
      6'b100010: r_alu = 3'b101;
      6'b101010: r_alu = 3'b110;
      6'b000100: r_alu = 3'b111;
      default:   r_ok  = 1'b0;
    endcase
    case (op)
      6'b001000: begin
        i_alu  = 3'b100;
        i_srcb = 2'b01;
      end
      6'b001100: i_alu = 3'b000;
      6'b001101: i_alu = 3'b001;
      6'b001110: i_alu = 3'b010;
      default:   i_ok  = 1'b0;
    endcase
  end

  assign is_r  = (op == 6'b000000) & r_ok;
  assign is_i  = i_ok;
  assign is_m  = (op == 6'b100011) |
                 (op == 6'b101011);
  assign is_br = (op[5:1] == 5'b00010);
  assign is_j  = (op == 6'b000010);
  assign is_ill = ~(is_r | is_i | is_m |
                    is_br | is_j);

  // WB re-derives these from the stable IR so ALU_F holds
  assign ex_alu  = (op == 6'b000000) ? r_alu : i_alu;
  assign ex_srcb = (op == 6'b000000) ? 2'b00 : i_srcb;

  // State, retired count and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IF;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (dn_c)
        instr_cnt <= instr_cnt + CNT_W'(1);
      if (state == S_ID && is_ill)
        illegal <= 1'b1;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        unique case (1'b1)
          is_r:    state_nxt = S_EXR;
          is_i:    state_nxt = S_EXI;
          is_m:    state_nxt = S_MADDR;
          is_br:   state_nxt = S_BR;
          is_j:    state_nxt = S_J;
          default: state_nxt = ILLEGAL_HALT ?
                               S_HALT : S_IF;
        endcase
      end
      S_EXR:   state_nxt = S_WB;
      S_EXI:   state_nxt = S_WB;
      S_MADDR: state_nxt = op[3] ? S_MWR : S_MRD;
      S_MRD:   state_nxt = S_MWB;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Per-state datapath controls, before reset gating
  always_comb begin
    pw_c = 1'b0;
    ps_c = 2'b00;
    iw_c = 1'b0;
    rw_c = 1'b0;
    rs_c = 1'b0;
    ws_c = 1'b0;
    sb_c = 2'b00;
    ao_c = 3'b100;
    fw_c = 1'b0;
    mw_c = 1'b0;
    dn_c = 1'b0;
    case (state)
      S_IF: begin
        iw_c = 1'b1;
        pw_c = 1'b1;
      end
      S_ID: dn_c = is_ill;
      S_EXR, S_EXI: begin
        sb_c = ex_srcb;
        ao_c = ex_alu;
        fw_c = 1'b1;
      end
      S_WB: begin
        sb_c = ex_srcb;
        ao_c = ex_alu;
        rw_c = 1'b1;
        rs_c = (op == 6'b000000);
        dn_c = 1'b1;
      end
      S_MADDR, S_MRD: sb_c = 2'b01;
      S_MWB: begin
        sb_c = 2'b01;
        rw_c = 1'b1;
        ws_c = 1'b1;
        dn_c = 1'b1;
      end
      S_MWR: begin
        sb_c = 2'b01;
        mw_c = 1'b1;
        dn_c = 1'b1;
      end
      S_BR: begin
        ao_c = 3'b101;
        ps_c = 2'b01;
        pw_c = op[0] ? ~zf : zf;
        dn_c = 1'b1;
      end
      S_J: begin
        ps_c = 2'b10;
        pw_c = 1'b1;
        dn_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write   = pw_c & ~rst;
  assign ir_write   = iw_c & ~rst;
  assign reg_write  = rw_c & ~rst;
  assign fr_write   = fw_c & ~rst;
  assign mem_write  = mw_c & ~rst;
  assign instr_done = dn_c & ~rst;
  assign pc_src     = rst ? 2'b00 : ps_c;
  assign rd_sel     = rs_c & ~rst;
  assign wb_sel     = ws_c & ~rst;
  assign alu_src_b  = rst ? 2'b00 : sb_c;
  assign alu_op     = rst ? 3'b100 : ao_c;
  assign state_dbg  = state;

endmodule

// File: tb/tb_ricpu_ctrl.sv
// Randomized bench for ricpu_ctrl against an
// instruction-level model of the control sequence.
module tb_ricpu_ctrl;

  localparam int CR = 0, CI = 1, CLW = 2, CSW = 3;
  localparam int CBR = 4, CJ = 5, CILL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] op, funct;
  logic       zf;

  logic       a_pw, a_iw, a_rw, a_rs, a_ws;
  logic       a_fw, a_mw, a_dn, a_ill;
  logic [1:0] a_ps, a_sb;
  logic [2:0] a_ao;
  logic [3:0] a_cnt, a_st;

  logic        b_pw, b_iw, b_rw, b_rs, b_ws;
  logic        b_fw, b_mw, b_dn, b_ill;
  logic [1:0]  b_ps, b_sb;
  logic [2:0]  b_ao;
  logic [31:0] b_cnt;
  logic [3:0]  b_st;

  ricpu_ctrl #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zf(zf), .pc_write(a_pw), .pc_src(a_ps),
    .ir_write(a_iw), .reg_write(a_rw),
    .rd_sel(a_rs), .wb_sel(a_ws),
    .alu_src_b(a_sb), .alu_op(a_ao),
    .fr_write(a_fw), .mem_write(a_mw),
    .instr_done(a_dn), .illegal(a_ill),
    .instr_cnt(a_cnt), .state_dbg(a_st)
  );

  ricpu_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zf(zf), .pc_write(b_pw), .pc_src(b_ps),
    .ir_write(b_iw), .reg_write(b_rw),
    .rd_sel(b_rs), .wb_sel(b_ws),
    .alu_src_b(b_sb), .alu_op(b_ao),
    .fr_write(b_fw), .mem_write(b_mw),
    .instr_done(b_dn), .illegal(b_ill),
    .instr_cnt(b_cnt), .state_dbg(b_st)
  );

  int pass_n = 0;
  int tot_n  = 0;

  bit          chk_en = 1'b0;
  bit          chk_b  = 1'b0;
  logic [18:0] exp_vec;
  int          cnt_m;
  bit          ill_m;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s got=%0h want=%0h t=%0t",
                  nm, act, exp, $time);
  endtask

  function automatic int r_alu(input logic [5:0] f);
    case (f)
      6'b100100: return 0;
      6'b100101: return 1;
      6'b100110: return 2;
      6'b100111: return 3;
      6'b100000: return 4;
      6'b100010: return 5;
      6'b101010: return 6;
      6'b000100: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic int i_alu(input logic [5:0] o);
    case (o)
      6'b001000: return 4;
      6'b001100: return 0;
      6'b001101: return 1;
      6'b001110: return 2;
      default:   return -1;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] o,
                                  input logic [5:0] f);
    if (o == 6'd0) return (r_alu(f) >= 0) ? CR : CILL;
    if (i_alu(o) >= 0) return CI;
    if (o == 6'b100011) return CLW;
    if (o == 6'b101011) return CSW;
    if (o == 6'b000100 || o == 6'b000101) return CBR;
    if (o == 6'b000010) return CJ;
    return CILL;
  endfunction

  function automatic int lat(input int c);
    case (c)
      CR, CI, CSW: return 4;
      CLW:         return 5;
      CBR, CJ:     return 3;
      default:     return 2;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction of class c
  function automatic logic [18:0] exp_at(
      input int c, input int k,
      input logic [5:0] o, input logic [5:0] f,
      input logic z);
    logic [3:0] st;
    logic       pw, iw, rw, rs, ws, fw, mw, dn;
    logic [1:0] ps, sb;
    logic [2:0] ao;
    st = 0; pw = 0; iw = 0; rw = 0; rs = 0; ws = 0;
    fw = 0; mw = 0; dn = 0; ps = 0; sb = 0; ao = 3'd4;
    if (k == 0) begin
      iw = 1; pw = 1;
    end else if (k == 1) begin
      st = 1; dn = (c == CILL);
    end else begin
      case (c)
        CR: begin
          ao = 3'(r_alu(f));
          if (k == 2) begin st = 2; fw = 1; end
          else begin st = 4; rw = 1; rs = 1; dn = 1; end
        end
        CI: begin
          ao = 3'(i_alu(o));
          sb = (o == 6'b001000) ? 2'd1 : 2'd2;
          if (k == 2) begin st = 3; fw = 1; end
          else begin st = 4; rw = 1; dn = 1; end
        end
        CLW: begin
          sb = 1;
          st = (k == 2) ? 4'd5 : (k == 3) ? 4'd6 : 4'd7;
          if (k == 4) begin rw = 1; ws = 1; dn = 1; end
        end
        CSW: begin
          sb = 1;
          st = (k == 2) ? 4'd5 : 4'd8;
          if (k == 3) begin mw = 1; dn = 1; end
        end
        CBR: begin
          st = 9; ao = 3'd5; ps = 1; dn = 1;
          pw = o[0] ? ~z : z;
        end
        CJ: begin
          st = 10; pw = 1; ps = 2; dn = 1;
        end
        default: ;
      endcase
    end
    return {st, pw, ps, iw, rw, rs, ws, sb, ao, fw, mw, dn};
  endfunction

  // Per-cycle comparison of DUT A against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("outs", {a_st, a_pw, a_ps, a_iw, a_rw, a_rs,
                     a_ws, a_sb, a_ao, a_fw, a_mw, a_dn},
            exp_vec);
      check("cnt", a_cnt, 32'(cnt_m));
      check("illegal", a_ill, ill_m);
    end
    if (chk_b) begin
      check("halt_st", b_st, 15);
      check("halt_en", {b_pw, b_iw, b_rw, b_fw,
                        b_mw, b_dn}, 0);
    end
  end

  task automatic do_reset();
    chk_en = 0;
    rst = 1;
    op = 6'($urandom);
    @(negedge clk);
    check("rst_en", {a_pw, a_iw, a_rw, a_fw, a_mw, a_dn}, 0);
    check("rst_sel", {a_ps, a_rs, a_ws, a_sb, a_ao}, 3'b100);
    @(posedge clk); #1;
    rst = 0;
    cnt_m = 0;
    ill_m = 0;
    check("rst_state", a_st, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ill", a_ill, 0);
  endtask

  // zmode<0 random zf; abort_k>=0 pulses rst at that cycle
  task automatic do_instr(input logic [5:0] o,
                          input logic [5:0] f,
                          input int zmode,
                          input int abort_k);
    int c;
    c = classify(o, f);
    for (int k = 0; k < lat(c); k++) begin
      op = o;
      funct = f;
      zf = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      if (k == abort_k) begin
        chk_en = 0;
        rst = 1;
        @(negedge clk);
        check("ab_st", a_st, 5);
        check("ab_en", {a_pw, a_rw, a_mw, a_fw, a_dn}, 0);
        check("ab_sel", {a_sb, a_ao}, 5'b00100);
        @(posedge clk); #1;
        rst = 0;
        cnt_m = 0;
        ill_m = 0;
        check("ab_state", a_st, 0);
        check("ab_cnt", a_cnt, 0);
        return;
      end
      exp_vec = exp_at(c, k, o, f, zf);
      chk_en = 1;
      @(posedge clk); #1;
      if (exp_vec[0]) cnt_m = (cnt_m + 1) % 16;
      if (c == CILL && k == 1) ill_m = 1;
    end
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [8];

  initial begin
    ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b100011, 6'b101011, 6'b000100,
            6'b000101, 6'b000010};
    fns = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b100000, 6'b100010, 6'b101010, 6'b000100};
    rst = 1;
    op = 0;
    funct = 0;
    zf = 0;
    cnt_m = 0;
    ill_m = 0;
    @(posedge clk); #1;
    do_reset();

    do_instr(6'b000000, 6'b100000, -1, -1);
    check("add_cnt", a_cnt, 1);
    do_instr(6'b100011, 6'($urandom), -1, -1);
    do_instr(6'b101011, 6'($urandom), -1, -1);
    check("lwsw_cnt", a_cnt, 3);
    do_instr(6'b000100, 6'd0, 1, -1);
    do_instr(6'b000100, 6'd0, 0, -1);
    do_instr(6'b000101, 6'd0, 0, -1);
    do_instr(6'b000101, 6'd0, 1, -1);
    check("br_cnt", a_cnt, 7);

    // Illegal: A returns to fetch, B parks in halt
    do_reset();
    do_instr(6'b111111, 6'($urandom), -1, -1);
    check("ill_a", a_ill, 1);
    check("ill_b", b_ill, 1);
    check("ill_bcnt", b_cnt, 1);
    chk_b = 1;
    do_instr(6'b000010, 6'd0, -1, -1);
    do_instr(6'b000000, 6'b100010, -1, -1);
    chk_b = 0;
    do_reset();
    check("b_clr_ill", b_ill, 0);
    check("b_clr_st", b_st, 0);

    // Reset while lw is in the address state
    do_instr(6'b000000, 6'b100101, -1, -1);
    do_instr(6'b100011, 6'd0, -1, 2);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 16; i++)
      do_instr(6'b000010, 6'($urandom), -1, -1);
    check("wrap0", a_cnt, 0);
    do_instr(6'b000010, 6'($urandom), -1, -1);
    check("wrap1", a_cnt, 1);

    // Randomized mix, including some illegal encodings
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, 9)];
      f = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) o = 6'($urandom);
      if ($urandom_range(0, 15) == 0) f = 6'($urandom);
      do_instr(o, f, -1, -1);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
